// File: rtl/mux4_1.sv
// mux4_1 -- single-bit 4:1 multiplexer with a registered copy and
// select-change monitoring.
//
// Purpose:
//   Steers one of four single-bit sources onto a shared line. The
//   combinational result is always live. A registered copy is provided for
//   timing-clean consumers, along with debug observability: the registered
//   select, a one-cycle select-change pulse, and a saturating count of
//   select changes.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   a,b,c,d    in   1      data inputs, selected by {s1,s0} = 00,01,10,11
//   s0, s1     in   1      select LSB / MSB
//   out        out  1      combinational mux result (not gated by reset)
//   out_q      out  1      out registered on clk
//   sel_q      out  2      registered {s1,s0}
//   sel_chg    out  1      pulse: sampled select differed from sel_q
//   chg_count  out  CNT_W  saturating count of select changes since reset

module mux4_1 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             s0,
    input  logic             s1,
    output logic             out,
    output logic             out_q,
    output logic [1:0]       sel_q,
    output logic             sel_chg,
    output logic [CNT_W-1:0] chg_count
);

    logic [1:0]       sel;
    logic             sel_diff;
    logic             cnt_sat;

    logic             out_reg;
    logic [1:0]       sel_reg;
    logic             chg_reg;
    logic [CNT_W-1:0] cnt_reg;

    assign sel = {s1, s0};

    // An unknown select falls through to the default branch, which yields X
    // in simulation. No cleanup logic is added for that case.
    always_comb begin
        case (sel)
            2'b00:   out = a;
            2'b01:   out = b;
            2'b10:   out = c;
            2'b11:   out = d;
            default: out = 1'bx;
        endcase
    end

    // A change is measured against the registered select. After reset,
    // sel_reg is 00, so a first non-00 select counts as a change.
    assign sel_diff = (sel != sel_reg);
    assign cnt_sat  = (cnt_reg == {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_reg <= 1'b0;
            sel_reg <= 2'b00;
            chg_reg <= 1'b0;
            cnt_reg <= '0;
        end else begin
            out_reg <= out;
            sel_reg <= sel;
            chg_reg <= sel_diff;
            if (sel_diff && !cnt_sat) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign out_q     = out_reg;
    assign sel_q     = sel_reg;
    assign sel_chg   = chg_reg;
    assign chg_count = cnt_reg;

endmodule

// File: tb/tb_mux4_1.sv
// tb_mux4_1 -- directed, scoreboard-based bench for mux4_1.
// Two instances share their inputs. One uses the default 8-bit counter and
// the other a 2-bit counter, so that saturation is reachable.

module tb_mux4_1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a, b, c, d, s0, s1;
    logic       out, out_q, sel_chg;
    logic [1:0] sel_q;
    logic [7:0] chg_count;
    logic       out2, out_q2, sel_chg2;
    logic [1:0] sel_q2;
    logic [1:0] chg_count2;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       outq;
        logic [1:0] sel;
        logic       chg;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
    } exp_t;

    exp_t sb_q[$];

    // Reference state for the registered outputs, kept independently of the DUT
    logic [1:0] m_sel  = 2'b00;
    logic [7:0] m_cnt8 = 8'd0;
    logic [1:0] m_cnt2 = 2'd0;

    always #5 clk = ~clk;

    mux4_1 dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .s0(s0), .s1(s1),
        .out(out), .out_q(out_q), .sel_q(sel_q), .sel_chg(sel_chg),
        .chg_count(chg_count)
    );

    mux4_1 #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .s0(s0), .s1(s1),
        .out(out2), .out_q(out_q2), .sel_q(sel_q2), .sel_chg(sel_chg2),
        .chg_count(chg_count2)
    );

    function automatic logic mux_ref(input logic [1:0] sel, input logic [3:0] dcba);
        case (sel)
            2'b00:   return dcba[0];
            2'b01:   return dcba[1];
            2'b10:   return dcba[2];
            default: return dcba[3];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_in(input logic [1:0] sel, input logic [3:0] dcba);
        {s1, s0}     = sel;
        {d, c, b, a} = dcba;
    endtask

    // Drive one cycle of stimulus on the falling edge. Push the predicted
    // registered state, check the combinational output, then pop and compare
    // after the rising edge.
    task automatic step(input string tag, input logic rst, input logic [1:0] sel,
                        input logic [3:0] dcba);
        exp_t e;
        logic [31:0] comb_exp;
        exp_t got;
        @(negedge clk);
        rst_n = rst;
        set_in(sel, dcba);
        if (!rst) begin
            m_sel  = 2'b00;
            m_cnt8 = 8'd0;
            m_cnt2 = 2'd0;
            e = '{outq: 1'b0, sel: 2'b00, chg: 1'b0, cnt8: 8'd0, cnt2: 2'd0};
        end else begin
            e.outq = mux_ref(sel, dcba);
            e.chg  = (sel != m_sel);
            if (e.chg && m_cnt8 != 8'hFF) m_cnt8 = m_cnt8 + 8'd1;
            if (e.chg && m_cnt2 != 2'h3)  m_cnt2 = m_cnt2 + 2'd1;
            m_sel  = sel;
            e.sel  = sel;
            e.cnt8 = m_cnt8;
            e.cnt2 = m_cnt2;
        end
        sb_q.push_back(e);
        #1;
        comb_exp = {31'd0, mux_ref(sel, dcba)};
        chk({tag, ".out"}, {31'd0, out}, comb_exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            chk({tag, ".out_q"},      {31'd0, out_q},      {31'd0, got.outq});
            chk({tag, ".sel_q"},      {30'd0, sel_q},      {30'd0, got.sel});
            chk({tag, ".sel_chg"},    {31'd0, sel_chg},    {31'd0, got.chg});
            chk({tag, ".chg_count"},  {24'd0, chg_count},  {24'd0, got.cnt8});
            chk({tag, ".chg_count2"}, {30'd0, chg_count2}, {30'd0, got.cnt2});
            chk({tag, ".out_q2"},     {31'd0, out_q2},     {31'd0, got.outq});
        end
        $display("[TB] %s rst_n=%0b sel=%0b dcba=%4b -> out_q=%0b sel_q=%0b chg=%0b cnt=%0d cnt2=%0d",
                 tag, rst, sel, dcba, out_q, sel_q, sel_chg, chg_count, chg_count2);
    endtask

    initial begin : main
        logic [1:0] seq_sel [5];
        logic       seq_chg [5];
        logic [7:0] seq_cnt [5];
        logic [1:0] sat_sel [5];
        logic [1:0] sv;

        rst_n = 1'b0;
        set_in(2'b00, 4'b0000);

        // Free-running stimulus: d/c/b/a toggle every 5/10/20/40 units and
        // s0/s1 every 80/160, over 500 units
        for (int k = 0; k < 100; k++) begin
            int t;
            t = k * 5;
            s1 = 1'((t / 160) % 2);
            s0 = 1'((t / 80) % 2);
            a  = 1'((t / 40) % 2);
            b  = 1'((t / 20) % 2);
            c  = 1'((t / 10) % 2);
            d  = 1'((t / 5) % 2);
            #1;
            chk($sformatf("free.t%0d", t), {31'd0, out},
                {31'd0, mux_ref({s1, s0}, {d, c, b, a})});
            $display("[TB] free t=%0d sel=%0b dcba=%0b%0b%0b%0b out=%0b", t, {s1, s0}, d, c, b, a, out);
            #4;
        end

        // Static selection with each input singly high
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 4; s++) begin
                sv = 2'(s);
                set_in(sv, 4'(1 << i));
                #1;
                chk($sformatf("static.in%0d.sel%0d", i, s), {31'd0, out}, {31'd0, (s == i)});
                $display("[TB] static in=%0d sel=%0d out=%0b", i, s, out);
            end
        end

        // Registered path
        step("rst0", 1'b0, 2'b00, 4'b0000);
        step("rst1", 1'b0, 2'b00, 4'b0000);
        step("reg.sel10", 1'b1, 2'b10, 4'b0100);
        chk("reg.cnt_is_1", {24'd0, chg_count}, 32'd1);
        chk("reg.chg_is_1", {31'd0, sel_chg}, 32'd1);
        step("reg.hold", 1'b1, 2'b10, 4'b0100);
        chk("reg.chg_drop", {31'd0, sel_chg}, 32'd0);

        // Change counting: 00,01,01,11,00
        step("cnt.rst", 1'b0, 2'b00, 4'b0000);
        seq_sel = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b00};
        seq_chg = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        seq_cnt = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3};
        for (int i = 0; i < 5; i++) begin
            step($sformatf("cnt.%0d", i), 1'b1, seq_sel[i], 4'b1010);
            chk($sformatf("cnt.tab_chg%0d", i), {31'd0, sel_chg}, {31'd0, seq_chg[i]});
            chk($sformatf("cnt.tab_cnt%0d", i), {24'd0, chg_count}, {24'd0, seq_cnt[i]});
        end

        // Saturation: five more consecutive changes; the 2-bit counter holds at 3
        sat_sel = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        for (int i = 0; i < 5; i++) begin
            step($sformatf("sat.%0d", i), 1'b1, sat_sel[i], 4'b0011);
        end
        chk("sat.cnt2_held", {30'd0, chg_count2}, 32'd3);
        chk("sat.cnt8", {24'd0, chg_count}, 32'd8);

        // Mid-operation reset with out_q=1 (sel=01, b=1)
        step("mid.pre", 1'b1, 2'b01, 4'b0010);
        chk("mid.outq_set", {31'd0, out_q}, 32'd1);
        step("mid.rst", 1'b0, 2'b11, 4'b1000);
        chk("mid.cnt_clr", {24'd0, chg_count}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            sv = 2'(i);
            set_in(sv, 4'b0101);
            #1;
            chk($sformatf("mid.live%0d", i), {31'd0, out}, {31'd0, mux_ref(sv, 4'b0101)});
            $display("[TB] mid.live sel=%0d out=%0b", i, out);
        end
        step("mid.rst_hold", 1'b0, 2'b10, 4'b0100);
        step("mid.release", 1'b1, 2'b00, 4'b0001);
        chk("mid.rel_nochg", {31'd0, sel_chg}, 32'd0);

        // Data-only changes never register as select changes
        step("data.0", 1'b1, 2'b00, 4'b0000);
        step("data.1", 1'b1, 2'b00, 4'b1111);
        chk("data.no_cnt", {24'd0, chg_count}, 32'd0);
        // Select and data change together: new select on new data
        step("both", 1'b1, 2'b11, 4'b1000);
        chk("both.outq", {31'd0, out_q}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
